// File: rtl/data_memory_ctrl_if.sv
// Request/response bus between the MEM-stage requester (master) and
// data_memory_ctrl (slave): valid/ready request channel plus a response strobe.
interface data_memory_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/data_memory_ctrl.sv
// Byte-addressed data memory with byte/half/word access, programmable wait
// states and fault reporting for misaligned, out-of-range or reserved accesses.
module data_memory_ctrl #(
  parameter int DEPTH   = 1024,  // 32-bit words, power of 2, >= 4
  parameter int LATENCY = 1      // 1..15 cycles from acceptance to response
) (
  input  logic              clk,
  input  logic              reset,
  data_memory_ctrl_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_t;

  state_t      state;
  logic [3:0]  wait_cnt;
  logic        req_ready_q, resp_valid_q, resp_err_q;
  logic [31:0] resp_rdata_q;

  // Request captured at acceptance; pure data, qualified by state.
  logic        q_write, q_signed;
  logic [1:0]  q_size;
  logic [31:0] q_addr, q_wdata;

  // NOTE: the array has no reset branch -- reset only restarts the FSM, so the
  // contents survive it and start at zero purely through this initialiser.
  logic [31:0] mem [DEPTH] = '{default: '0};

  // The access being completed: straight from the bus when LATENCY==1 (the
  // commit edge is the acceptance edge), otherwise the captured copy.
  logic        a_write, a_signed;
  logic [1:0]  a_size;
  logic [31:0] a_addr, a_wdata;
  logic [AW-1:0] widx;
  logic        a_err, enter_resp;
  logic [3:0]  be;
  logic [31:0] wdata_rep, rd_word, shifted, load_data, resp_next;

  always_comb begin
    if (state == IDLE) begin
      a_write  = bus.req_write;
      a_signed = bus.req_signed;
      a_size   = bus.req_size;
      a_addr   = bus.req_addr;
      a_wdata  = bus.req_wdata;
    end else begin
      a_write  = q_write;
      a_signed = q_signed;
      a_size   = q_size;
      a_addr   = q_addr;
      a_wdata  = q_wdata;
    end
  end

  assign widx  = a_addr[AW+1:2];
  assign a_err = (a_size == SZ_RSVD)
              || (a_size == SZ_HALF && a_addr[0])
              || (a_size == SZ_WORD && a_addr[1:0] != 2'b00)
              || (a_addr[31:AW+2] != '0);

  assign enter_resp = !reset
                   && ((state == IDLE && bus.req_valid && LATENCY == 1)
                    || (state == WAIT && wait_cnt == 4'd1));

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    be        = 4'b0000;
    wdata_rep = {4{a_wdata[7:0]}};
    case (a_size)
      SZ_BYTE: be = 4'b0001 << a_addr[1:0];
      SZ_HALF: begin
        be        = a_addr[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{a_wdata[15:0]}};
      end
      SZ_WORD: begin
        be        = 4'b1111;
        wdata_rep = a_wdata;
      end
      default: be = 4'b0000;
    endcase
  end

  always_comb begin
    rd_word   = mem[widx];
    shifted   = rd_word >> {a_addr[1:0], 3'b000};
    load_data = '0;
    case (a_size)
      SZ_BYTE: load_data = {{24{a_signed & shifted[7]}}, shifted[7:0]};
      SZ_HALF: load_data = {{16{a_signed & shifted[15]}}, shifted[15:0]};
      SZ_WORD: load_data = shifted;
      default: load_data = '0;
    endcase
    resp_next = (a_err || a_write) ? 32'h0 : load_data;
  end

  // Byte-enable commit on the edge entering RESP; reset wins over the write.
  always_ff @(posedge clk) begin
    if (enter_resp && a_write && !a_err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[widx][8*i +: 8] <= wdata_rep[8*i +: 8];
      end
    end
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            q_write     <= bus.req_write;
            q_signed    <= bus.req_signed;
            q_size      <= bus.req_size;
            q_addr      <= bus.req_addr;
            q_wdata     <= bus.req_wdata;
            req_ready_q <= 1'b0;
            if (LATENCY == 1) begin
              state        <= RESP;
              resp_valid_q <= 1'b1;
              resp_rdata_q <= resp_next;
              resp_err_q   <= a_err;
            end else begin
              state    <= WAIT;
              wait_cnt <= 4'(LATENCY - 1);
            end
          end
        end
        WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt == 4'd1) begin
            state        <= RESP;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= resp_next;
            resp_err_q   <= a_err;
          end
        end
        RESP: begin
          state        <= IDLE;
          req_ready_q  <= 1'b1;
          resp_valid_q <= 1'b0;
        end
        default: begin
          state        <= IDLE;
          req_ready_q  <= 1'b1;
          resp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench for data_memory_ctrl: three builds (LATENCY 1, 4, 3) on one
// clock, each with its own reset and bus instance.
module tb_data_memory_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_a, reset_b, reset_c;
  int   checks = 0;
  int   errors = 0;

  data_memory_ctrl_if bus_a ();
  data_memory_ctrl_if bus_b ();
  data_memory_ctrl_if bus_c ();

  data_memory_ctrl #(.DEPTH(1024), .LATENCY(1)) dut_a (.clk(clk), .reset(reset_a), .bus(bus_a.slave));
  data_memory_ctrl #(.DEPTH(1024), .LATENCY(4)) dut_b (.clk(clk), .reset(reset_b), .bus(bus_b.slave));
  data_memory_ctrl #(.DEPTH(1024), .LATENCY(3)) dut_c (.clk(clk), .reset(reset_c), .bus(bus_c.slave));

  localparam logic [1:0] B = 2'b00, H = 2'b01, W = 2'b10, R = 2'b11;

  task automatic drv(input int d, input logic v, input logic w, input logic [1:0] sz,
                     input logic sg, input logic [31:0] addr, input logic [31:0] wd);
    case (d)
      0: begin
        bus_a.req_valid = v; bus_a.req_write = w; bus_a.req_size = sz;
        bus_a.req_signed = sg; bus_a.req_addr = addr; bus_a.req_wdata = wd;
      end
      1: begin
        bus_b.req_valid = v; bus_b.req_write = w; bus_b.req_size = sz;
        bus_b.req_signed = sg; bus_b.req_addr = addr; bus_b.req_wdata = wd;
      end
      default: begin
        bus_c.req_valid = v; bus_c.req_write = w; bus_c.req_size = sz;
        bus_c.req_signed = sg; bus_c.req_addr = addr; bus_c.req_wdata = wd;
      end
    endcase
  endtask

  // {req_ready, resp_valid, resp_err, resp_rdata}
  function automatic logic [34:0] obs(input int d);
    case (d)
      0:       return {bus_a.req_ready, bus_a.resp_valid, bus_a.resp_err, bus_a.resp_rdata};
      1:       return {bus_b.req_ready, bus_b.resp_valid, bus_b.resp_err, bus_b.resp_rdata};
      default: return {bus_c.req_ready, bus_c.resp_valid, bus_c.resp_err, bus_c.resp_rdata};
    endcase
  endfunction

  task automatic set_reset(input int d, input logic v);
    case (d)
      0:       reset_a = v;
      1:       reset_b = v;
      default: reset_c = v;
    endcase
  endtask

  // One access; lat = negedges from acceptance to resp_valid, -1 on timeout.
  task automatic acc(input int d, input logic w, input logic [1:0] sz, input logic sg,
                     input logic [31:0] addr, input logic [31:0] wd,
                     output logic [31:0] rd, output logic er, output int lat);
    logic [34:0] o;
    @(negedge clk);
    drv(d, 1'b1, w, sz, sg, addr, wd);
    @(negedge clk);
    drv(d, 1'b0, 1'b0, W, 1'b0, 32'h0, 32'h0);
    lat = 1;
    o = obs(d);
    while (!o[33] && lat < 40) begin
      @(negedge clk);
      lat++;
      o = obs(d);
    end
    if (!o[33]) lat = -1;
    er = o[32];
    rd = o[31:0];
  endtask

  task automatic test_reset();
    logic [34:0] o;
    for (int d = 0; d < 3; d++) begin
      @(negedge clk);
      set_reset(d, 1'b1);
      repeat (2) @(negedge clk);
      set_reset(d, 1'b0);
      o = obs(d);
      checks++;
      if (o !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
        errors++;
        $display("FAIL reset_state dut%0d: got %h need %h", d, o, {1'b1, 1'b0, 1'b0, 32'h0});
      end
    end
  endtask

  // Single comparison of one LATENCY=1 access against hand-computed results.
  task automatic a_expect(input string name, input logic w, input logic [1:0] sz, input logic sg,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic exp_er);
    logic [31:0] rd;
    logic        er;
    int          lat;
    acc(0, w, sz, sg, addr, wd, rd, er, lat);
    checks++;
    if (lat !== 1 || rd !== exp_rd || er !== exp_er) begin
      errors++;
      $display("FAIL %s: lat=%0d rdata=%h err=%b, need lat=1 rdata=%h err=%b",
               name, lat, rd, er, exp_rd, exp_er);
    end
  endtask

  task automatic test_first_load();
    a_expect("first_word_load", 1'b0, W, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic test_store_merge();
    a_expect("store_word_0x10", 1'b1, W, 1'b0, 32'h10, 32'hA1B2C3D4, 32'h0, 1'b0);
    a_expect("store_byte_0x12", 1'b1, B, 1'b0, 32'h12, 32'hFFFFFF55, 32'h0, 1'b0);
    a_expect("merged_load_0x10", 1'b0, W, 1'b0, 32'h10, 32'h0, 32'hA155C3D4, 1'b0);
    a_expect("store_half_0x16", 1'b1, H, 1'b0, 32'h16, 32'h7777BEEF, 32'h0, 1'b0);
    a_expect("half_lane_load_0x14", 1'b0, W, 1'b0, 32'h14, 32'h0, 32'hBEEF0000, 1'b0);
  endtask

  task automatic test_extend();
    a_expect("sbyte_0x13", 1'b0, B, 1'b1, 32'h13, 32'h0, 32'hFFFFFFA1, 1'b0);
    a_expect("ubyte_0x13", 1'b0, B, 1'b0, 32'h13, 32'h0, 32'h000000A1, 1'b0);
    a_expect("shalf_0x10", 1'b0, H, 1'b1, 32'h10, 32'h0, 32'hFFFFC3D4, 1'b0);
    a_expect("uhalf_0x12", 1'b0, H, 1'b0, 32'h12, 32'h0, 32'h0000A155, 1'b0);
    a_expect("shalf_0x12", 1'b0, H, 1'b1, 32'h12, 32'h0, 32'hFFFFA155, 1'b0);
    a_expect("sbyte_pos_0x12", 1'b0, B, 1'b1, 32'h12, 32'h0, 32'h00000055, 1'b0);
  endtask

  task automatic test_errors();
    a_expect("err_half_0x11", 1'b0, H, 1'b1, 32'h11, 32'h0, 32'h0, 1'b1);
    a_expect("err_word_st_0x22", 1'b1, W, 1'b0, 32'h22, 32'hFFFFFFFF, 32'h0, 1'b1);
    a_expect("after_err_0x20", 1'b0, W, 1'b0, 32'h20, 32'h0, 32'h0, 1'b0);
    a_expect("err_size11_st", 1'b1, R, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1);
    a_expect("after_size11_0x10", 1'b0, W, 1'b0, 32'h10, 32'h0, 32'hA155C3D4, 1'b0);
    a_expect("err_range_st", 1'b1, W, 1'b0, 32'h1000, 32'hFFFFFFFF, 32'h0, 1'b1);
    a_expect("err_range_ld", 1'b0, W, 1'b0, 32'h1000, 32'h0, 32'h0, 1'b1);
    a_expect("no_alias_0x0", 1'b0, W, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    a_expect("last_word_st", 1'b1, W, 1'b0, 32'hFFC, 32'h89ABCDEF, 32'h0, 1'b0);
    a_expect("last_word_ld", 1'b0, W, 1'b0, 32'hFFC, 32'h0, 32'h89ABCDEF, 1'b0);
  endtask

  task automatic test_latency4();
    logic [34:0] o;
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          pulses = 0;
    @(negedge clk);
    drv(1, 1'b1, 1'b1, W, 1'b0, 32'h8, 32'h11223344);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      o = obs(1);
      pulses += int'(o[33]);
      checks++;
      if (o[34] !== (k >= 5) || o[33] !== (k == 4)) begin
        errors++;
        $display("FAIL lat4_cycle%0d: ready=%b valid=%b, need ready=%b valid=%b",
                 k, o[34], o[33], (k >= 5), (k == 4));
      end
      if (k == 1) drv(1, 1'b0, 1'b0, W, 1'b0, 32'h0, 32'h0);
      if (k == 2) drv(1, 1'b1, 1'b0, W, 1'b0, 32'h8, 32'h0);
      if (k == 3) drv(1, 1'b0, 1'b0, W, 1'b0, 32'h0, 32'h0);
    end
    checks++;
    if (pulses !== 1) begin
      errors++;
      $display("FAIL lat4_single_resp: pulses=%0d need 1", pulses);
    end
    acc(1, 1'b0, W, 1'b0, 32'h8, 32'h0, rd, er, lat);
    checks++;
    if (lat !== 4 || rd !== 32'h11223344 || er !== 1'b0) begin
      errors++;
      $display("FAIL lat4_load: lat=%0d rdata=%h err=%b, need lat=4 rdata=11223344 err=0", lat, rd, er);
    end
  endtask

  // Store on the LATENCY=3 build with reset asserted at negedge rst_k.
  task automatic abort_store(input string name, input logic [31:0] addr,
                             input logic [31:0] wd, input int rst_k);
    logic [34:0] o;
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          pulses = 0;
    @(negedge clk);
    drv(2, 1'b1, 1'b1, W, 1'b0, addr, wd);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      o = obs(2);
      pulses += int'(o[33]);
      if (k == rst_k + 1) begin
        checks++;
        if (o !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
          errors++;
          $display("FAIL %s_outputs: got %h need %h", name, o, {1'b1, 1'b0, 1'b0, 32'h0});
        end
      end
      if (k == 1) drv(2, 1'b0, 1'b0, W, 1'b0, 32'h0, 32'h0);
      if (k == rst_k) reset_c = 1'b1;
      if (k == rst_k + 1) reset_c = 1'b0;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL %s_no_resp: pulses=%0d need 0", name, pulses);
    end
    acc(2, 1'b0, W, 1'b0, addr, 32'h0, rd, er, lat);
    checks++;
    if (lat !== 3 || rd !== 32'h0 || er !== 1'b0) begin
      errors++;
      $display("FAIL %s_reload: lat=%0d rdata=%h err=%b, need lat=3 rdata=00000000 err=0", name, lat, rd, er);
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd;
    logic        er;
    int          lat;
    abort_store("abort_in_wait", 32'h40, 32'hDEADBEEF, 1);
    abort_store("abort_at_commit", 32'h44, 32'hCAFEF00D, 2);
    acc(2, 1'b1, W, 1'b0, 32'h48, 32'h01020304, rd, er, lat);
    acc(2, 1'b0, W, 1'b0, 32'h48, 32'h0, rd, er, lat);
    checks++;
    if (lat !== 3 || rd !== 32'h01020304 || er !== 1'b0) begin
      errors++;
      $display("FAIL lat3_store_load: lat=%0d rdata=%h err=%b, need lat=3 rdata=01020304 err=0", lat, rd, er);
    end
  endtask

  initial begin
    reset_a = 1'b0;
    reset_b = 1'b0;
    reset_c = 1'b0;
    for (int d = 0; d < 3; d++) drv(d, 1'b0, 1'b0, W, 1'b0, 32'h0, 32'h0);
    test_reset();
    test_first_load();
    test_store_merge();
    test_extend();
    test_errors();
    test_latency4();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/data_memory_ctrl.md
Name: data_memory_ctrl

Overview:
- Parametrised successor of the single-cycle data memory used by the datapath's MEM stage.
- Byte-addressed word array with byte, halfword and word loads and stores; loads are sign- or zero-extended.
- Uses a valid/ready request channel and a response strobe, with a programmable number of wait states.
- Flags misaligned, out-of-range and reserved-size accesses instead of silently wrapping.

Parameters:
- DEPTH, 1024: number of 32-bit words; must be a power of 2, at least 4.
- LATENCY, 1: cycles from request acceptance to response; range 1..15.
- AW, $clog2(DEPTH): word-index width; derived, not overridden.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; right-aligned (bits [7:0] for byte, [15:0] for half).
- resp_valid  out  1  one-cycle response strobe.
- resp_rdata  out  32  load result; 0 for stores and errored accesses.
- resp_err  out  1  access faulted; valid with resp_valid.

Behaviour:
- Reset: clk and reset are one clock with synchronous, active-high reset.
  - State goes to IDLE; req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0; wait counter=0.
  - Memory contents are NOT cleared by reset. They are initialised to 0 at time zero only.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready=1. On req_valid, latch write, size, signed, addr and wdata. Go to RESP if LATENCY==1, else go to WAIT with counter=LATENCY-1.
  - WAIT: req_ready=0. Decrement the counter; go to RESP when the counter reaches 1.
  - RESP: req_ready=0 and resp_valid=1 for exactly this one cycle; next state is IDLE.
- Latency and throughput:
  - A request accepted at edge N produces resp_valid high during cycle N+LATENCY.
  - Throughput is one access per LATENCY+1 cycles.
  - Only one access is ever outstanding.
- Word index is addr[AW+1:2]; byte lane is addr[1:0].
- Error checks, evaluated on the latched request:
  - Size 11: error.
  - Half with addr[0]=1: error.
  - Word with addr[1:0]!=0: error.
  - addr >= 4*DEPTH: error.
  - On error: no memory write, resp_rdata=0, resp_err=1.
- Store commit:
  - The array is written on the clock edge that enters RESP, never earlier.
  - Byte store updates lane addr[1:0]; half store updates lanes {addr[1],0} and {addr[1],1}; word store updates all four lanes.
  - All other lanes are preserved (byte-enable write, no read-modify-write race).
- Load:
  - The word is read when entering RESP.
  - The selected lane(s) are shifted down to bit 0.
  - Bits above the loaded size are filled with the MSB of the loaded field if req_signed=1, else with 0.
  - Little-endian: lane 0 = bits [7:0].
- resp_rdata and resp_err hold their last value outside RESP; consumers must qualify them with resp_valid.
- Reset mid-operation (in WAIT or at the RESP edge): the access is abandoned and no response is issued.
  - A store still in WAIT is discarded.
  - A store whose commit edge coincides with reset asserted is also discarded, because reset has priority over the write.
- req_valid while req_ready=0 is ignored. The requester must hold the request until it sees req_ready, or re-present it.
- A load issued to the address of a store that completed earlier returns the new data.

Test Plan:
- Reset then word load from 0x0 (LATENCY=1) -> resp_valid one cycle after acceptance, resp_rdata=0x00000000, resp_err=0.
- Word store 0xA1B2C3D4 to 0x10, then byte store 0x55 to 0x12, then word load from 0x10 -> 0xA155C3D4.
- From the 0xA155C3D4 word at 0x10: signed byte load from 0x13 -> 0xFFFFFFA1; unsigned -> 0x000000A1; signed half load from 0x10 -> 0xFFFFC3D4.
- Half load from 0x11, word store to 0x22, size 11, and any access to 0x1000 (DEPTH=1024) -> each gives resp_err=1, resp_rdata=0; a follow-up load confirms memory is unchanged.
- LATENCY=4 build: request at cycle 0 -> req_ready low cycles 1-4, resp_valid only in cycle 4; a req_valid in cycle 2 is ignored and produces no second response.
- LATENCY=3: word store 0xDEADBEEF to 0x40, reset asserted one cycle after acceptance -> no resp_valid; a later load of 0x40 returns the prior value 0x00000000 and outputs are at reset values.
